// File: rtl/led_matrix_top.sv
// HUB75 32x32 1/16-scan panel driver with a built-in three-lane game frame and divided game tick.
// Outputs are registered one cycle from the scan state; the scan is free-running with no backpressure.
module led_matrix_top #(
    parameter int COLS      = 32,
    parameter int ON_CYCLES = 256,
    parameter int GAME_DIV  = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       R0,
    output logic       G0,
    output logic       B0,
    output logic       R1,
    output logic       G1,
    output logic       B1,
    output logic       OE,
    output logic       LAT,
    output logic       clk_shft,
    output logic       clk_game_shft,
    output logic [3:1] led
);

    localparam int SHIFT_LEN = 2 * COLS;
    localparam int CNT_MAX   = (SHIFT_LEN > ON_CYCLES) ? SHIFT_LEN : ON_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX);
    localparam int GC_W      = $clog2(GAME_DIV);

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_LEN - 1);
    localparam logic [CNT_W-1:0] DISP_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [GC_W-1:0]  GC_LAST    = GC_W'(GAME_DIV - 1);
    localparam logic [GC_W-1:0]  GC_HALF    = GC_W'(GAME_DIV / 2);

    typedef enum logic [1:0] {S_SHIFT, S_LATCH, S_DISPLAY} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       row, row_nxt;
    logic [GC_W-1:0]  gc;
    logic [1:0]       lane;

    logic [15:0]      col;
    logic [15:0]      lane_lo;
    logic             in_lane;
    logic [5:0]       rgb_nxt;
    logic             rgb_load;

    // State registers describe the cycle about to be presented on the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_SHIFT;
            cnt   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            row   <= row_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        row_nxt   = row;
        case (state)
            S_SHIFT: begin
                if (cnt == SHIFT_LAST) begin
                    state_nxt = S_LATCH;
                    cnt_nxt   = '0;
                end
            end
            S_LATCH: begin
                state_nxt = S_DISPLAY;
                cnt_nxt   = '0;
            end
            S_DISPLAY: begin
                if (cnt == DISP_LAST) begin
                    state_nxt = S_SHIFT;
                    cnt_nxt   = '0;
                    row_nxt   = row + 4'd1;
                end
            end
            default: begin
                state_nxt = S_SHIFT;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pixel generator; RGB only reloads on the data phase so a lane change waits for the next column.
    always_comb begin
        col = 16'(cnt >> 1);
        case (lane)
            2'd1:    lane_lo = 16'd12;
            2'd2:    lane_lo = 16'd23;
            default: lane_lo = 16'd1;
        endcase
        in_lane  = (col >= lane_lo) && (col <= lane_lo + 16'd7);
        rgb_load = !((state == S_SHIFT) && cnt[0]);
        rgb_nxt  = '0;
        if (state == S_SHIFT) begin
            rgb_nxt[5] = in_lane;
            if (row == 4'd15) begin
                rgb_nxt[0] = 1'b1;
            end else begin
                rgb_nxt[2] = in_lane;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gc   <= '0;
            lane <= 2'd0;
        end else if (gc == GC_LAST) begin
            gc   <= '0;
            lane <= (lane == 2'd2) ? 2'd0 : lane + 2'd1;
        end else begin
            gc <= gc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {D, C, B, A}               <= 4'd0;
            {R0, G0, B0, R1, G1, B1}   <= 6'd0;
            OE                         <= 1'b1;
            LAT                        <= 1'b0;
            clk_shft                   <= 1'b0;
            clk_game_shft              <= 1'b0;
            led                        <= 3'b001;
        end else begin
            OE            <= (state != S_DISPLAY);
            LAT           <= (state == S_LATCH);
            clk_shft      <= (state == S_SHIFT) && cnt[0];
            clk_game_shft <= (gc >= GC_HALF);
            led           <= 3'b001 << lane;
            if (state == S_LATCH) begin
                {D, C, B, A} <= row;
            end
            if (rgb_load) begin
                {R0, G0, B0, R1, G1, B1} <= rgb_nxt;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_top.sv
// Bench for led_matrix_top: two instances (slow and fast game tick) compared every cycle
// against a cycle-index arithmetic model, plus literal spot checks on the first run after reset.
module tb_led_matrix_top;

    localparam int COLS = 32;
    localparam int ON   = 4;
    localparam int GDA  = 2000;
    localparam int GDB  = 8;
    localparam int P    = 2 * COLS + 1 + ON;

    localparam logic [16:0] RST_VEC  = 17'h00041;
    localparam logic [16:0] ALL_CARE = 17'h1FFFF;
    localparam logic [16:0] NO_RGB   = 17'h1E07F;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic a_A, a_B, a_C, a_D, a_R0, a_G0, a_B0, a_R1, a_G1, a_B1, a_OE, a_LAT, a_cs, a_cg;
    logic b_A, b_B, b_C, b_D, b_R0, b_G0, b_B0, b_R1, b_G1, b_B1, b_OE, b_LAT, b_cs, b_cg;
    logic [3:1] a_led, b_led;
    logic [16:0] pa, pb;

    led_matrix_top #(.COLS(COLS), .ON_CYCLES(ON), .GAME_DIV(GDA)) dut_a (
        .clk(clk), .rst(rst), .A(a_A), .B(a_B), .C(a_C), .D(a_D),
        .R0(a_R0), .G0(a_G0), .B0(a_B0), .R1(a_R1), .G1(a_G1), .B1(a_B1),
        .OE(a_OE), .LAT(a_LAT), .clk_shft(a_cs), .clk_game_shft(a_cg), .led(a_led)
    );

    led_matrix_top #(.COLS(COLS), .ON_CYCLES(ON), .GAME_DIV(GDB)) dut_b (
        .clk(clk), .rst(rst), .A(b_A), .B(b_B), .C(b_C), .D(b_D),
        .R0(b_R0), .G0(b_G0), .B0(b_B0), .R1(b_R1), .G1(b_G1), .B1(b_B1),
        .OE(b_OE), .LAT(b_LAT), .clk_shft(b_cs), .clk_game_shft(b_cg), .led(b_led)
    );

    assign pa = {a_D, a_C, a_B, a_A, a_R0, a_G0, a_B0, a_R1, a_G1, a_B1, a_OE, a_LAT, a_cs, a_cg, a_led};
    assign pb = {b_D, b_C, b_B, b_A, b_R0, b_G0, b_B0, b_R1, b_G1, b_B1, b_OE, b_LAT, b_cs, b_cg, b_led};

    int total = 0;
    int bad   = 0;
    int cyc   = -1;
    logic first_run = 1'b0;

    // Index of the cycle currently visible on the outputs; -1 while in reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= -1;
        else      cyc <= cyc + 1;
    end

    function automatic logic in_lane(int c, int l);
        return (c >= 1 + 11 * l) && (c <= 8 + 11 * l);
    endfunction

    function automatic logic [16:0] exp_out(int n, int gd);
        logic [16:0] e;
        int t, row, c, ld;
        e   = '0;
        t   = n % P;
        row = (n / P) % 16;
        e[3]   = (n % gd) >= gd / 2;
        e[2:0] = 3'(1 << ((n / gd) % 3));
        if (n >= 2 * COLS) e[16:13] = 4'(((n - 2 * COLS) / P) % 16);
        if (t < 2 * COLS) begin
            c  = t / 2;
            ld = ((n - t % 2) / gd) % 3;
            e[12] = in_lane(c, ld);
            if (row == 15) e[7] = 1'b1;
            else           e[9] = in_lane(c, ld);
            e[6] = 1'b1;
            e[4] = 1'(t % 2);
        end else if (t == 2 * COLS) begin
            e[6] = 1'b1;
            e[5] = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [16:0] care(int n);
        return ((n % P) == 2 * COLS) ? NO_RGB : ALL_CARE;
    endfunction

    task automatic chk(input string nm, input int n, input logic [16:0] got,
                       input logic [16:0] exp, input logic [16:0] mask);
        total++;
        if (((got ^ exp) & mask) != 17'h0) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h mask=%h", nm, n, got, exp, mask);
        end
    endtask

    task automatic chk_val(input string nm, input int n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, n, got, exp);
        end
    endtask

    int          bases[3] = '{0, 2001, 4002};
    logic [31:0] runs[3]  = '{32'h0000_01FE, 32'h000F_F000, 32'h7F80_0000};
    logic [31:0] r0m = '0;
    logic [31:0] b1m = '0;
    logic [31:0] r1m = '0;
    int          ncs = 0;

    always @(negedge clk) begin
        if (cyc < 0) begin
            chk("reset_a", cyc, pa, RST_VEC, ALL_CARE);
            chk("reset_b", cyc, pb, RST_VEC, ALL_CARE);
        end else begin
            chk("model_a", cyc, pa, exp_out(cyc, GDA), care(cyc));
            chk("model_b", cyc, pb, exp_out(cyc, GDB), care(cyc));
            if (first_run) begin
                for (int i = 0; i < 3; i++) begin
                    if (cyc >= bases[i] && cyc < bases[i] + 2 * COLS && ((cyc - bases[i]) % 2) == 0)
                        r0m[(cyc - bases[i]) / 2] = a_R0;
                    if (cyc == bases[i] + 2 * COLS)
                        chk_val("r0_lane_run", cyc, r0m, runs[i]);
                end
                if (cyc < 2 * COLS && a_cs) ncs++;
                if (cyc >= 15 * P && cyc < 15 * P + 2 * COLS && (cyc % 2) == 1) begin
                    b1m[(cyc - 15 * P) / 2] = a_B1;
                    r1m[(cyc - 15 * P) / 2] = a_R1;
                end
                case (cyc)
                    64: begin
                        chk_val("shift_pulses", cyc, ncs, 32);
                        chk_val("latch_row0", cyc, {27'b0, a_LAT, a_D, a_C, a_B, a_A}, 32'h10);
                    end
                    68:   chk_val("oe_on_last", cyc, {31'b0, a_OE}, 32'h0);
                    69:   chk_val("oe_off_row1", cyc, {30'b0, a_OE, a_LAT}, 32'h2);
                    133:  chk_val("latch_row1", cyc, {27'b0, a_LAT, a_D, a_C, a_B, a_A}, 32'h11);
                    1099: begin
                        chk_val("ground_b1", cyc, b1m, 32'hFFFF_FFFF);
                        chk_val("ground_r1", cyc, r1m, 32'h0);
                        chk_val("latch_row15", cyc, {27'b0, a_LAT, a_D, a_C, a_B, a_A}, 32'h1F);
                    end
                    1168: chk_val("addr_wrap", cyc, {27'b0, a_LAT, a_D, a_C, a_B, a_A}, 32'h10);
                    default: ;
                endcase
                case (cyc)
                    0:  chk_val("led_t0", cyc, {29'b0, b_led}, 32'h1);
                    3:  chk_val("gclk_lo", cyc, {31'b0, b_cg}, 32'h0);
                    4:  chk_val("gclk_rise", cyc, {31'b0, b_cg}, 32'h1);
                    7:  chk_val("gclk_hi", cyc, {31'b0, b_cg}, 32'h1);
                    8:  begin
                        chk_val("gclk_fall", cyc, {31'b0, b_cg}, 32'h0);
                        chk_val("led_t1", cyc, {29'b0, b_led}, 32'h2);
                    end
                    16: chk_val("led_t2", cyc, {29'b0, b_led}, 32'h4);
                    24: chk_val("led_t3", cyc, {29'b0, b_led}, 32'h1);
                    default: ;
                endcase
            end
        end
    end

    // Called just after a rising edge; asserts reset mid-cycle and checks the asynchronous clear.
    task automatic do_reset(input int off, input int hold);
        #(off);
        rst = 1'b0;
        first_run = 1'b0;
        #1;
        chk("rst_now_a", cyc, pa, RST_VEC, ALL_CARE);
        chk("rst_now_b", cyc, pb, RST_VEC, ALL_CARE);
        repeat (hold) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        first_run = 1'b1;
        repeat (4200) @(posedge clk);

        do_reset(2, 2);
        // Land in the display window of row 5, then reset there.
        repeat (5 * P + 2 * COLS + 3) @(posedge clk);
        do_reset(2, 3);

        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(1500, 30)) @(posedge clk);
            do_reset(($urandom_range(1, 0) == 1) ? 2 : 7, $urandom_range(10, 1));
        end
        repeat (1200) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
